// File: rtl/core_sramarb.sv
// core_sramarb: front end for one SRAM bank port.
// After reset it optionally zero-fills the bank so every word carries valid
// parity. It then shares the bank between NREQ requesters in round-robin
// order, honours bank stalls (m_ready low) and returns read valids to the
// requester that issued the read.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset release; samples initen
// INIT  | sweeps INITVAL over words 0..WCNT-1 with full byte enables
// RUN   | round-robin arbitration of req_* onto m_*
module core_sramarb #(
  parameter int              NREQ    = 2,
  parameter int              AW      = 17,
  parameter int              DW      = 64,
  parameter int              BC      = DW/8,
  parameter int              WCNT    = 2**AW,
  parameter logic [DW-1:0]   INITVAL = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 initen,
  input  logic                 initreq,
  output logic                 initdone,
  input  logic [NREQ-1:0]      req_cs,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*BC-1:0]   req_wr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      req_rvalid,
  output logic [DW-1:0]        req_rdata,
  output logic                 m_cs,
  output logic [AW-1:0]        m_addr,
  output logic [BC-1:0]        m_wr,
  output logic [DW-1:0]        m_wdata,
  input  logic [DW-1:0]        m_rdata,
  input  logic                 m_ready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // ic is one bit wider than the address so a full 2**AW sweep can be counted.
  localparam logic [AW:0] IC_LAST = (AW+1)'(WCNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     ic_q;
  logic            initdone_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   rown_q;
  logic            rpend_q;
  logic [PW-1:0]   g;
  logic            gvalid;
  logic            m_acc;

  assign m_acc     = m_cs & m_ready;
  assign initdone  = initdone_q;
  assign req_rdata = m_rdata;

  // Round-robin grant: first active requester at or after ptr, wrapping.
  always_comb begin
    gvalid = 1'b0;
    g      = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gvalid && req_cs[(int'(ptr_q) + k) % NREQ]) begin
        gvalid = 1'b1;
        g      = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Bank request mux, requester handshake and next-state decode.
  always_comb begin
    state_d   = state_q;
    m_cs      = 1'b0;
    m_addr    = '0;
    m_wr      = '0;
    m_wdata   = '0;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        state_d = initen ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        m_cs    = 1'b1;
        m_addr  = ic_q[AW-1:0];
        m_wr    = '1;
        m_wdata = INITVAL;
        if (m_ready && (ic_q == IC_LAST)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (gvalid) begin
          m_cs         = 1'b1;
          m_addr       = req_addr[int'(g)*AW +: AW];
          m_wr         = req_wr[int'(g)*BC +: BC];
          m_wdata      = req_wdata[int'(g)*DW +: DW];
          req_ready[g] = m_ready;
        end
        // The current cycle's accept still completes; the sweep starts next cycle.
        if (initreq) state_d = ST_INIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-valid pulse is a pure decode of the registered read owner.
  always_comb begin
    req_rvalid = '0;
    if (rpend_q) req_rvalid[rown_q] = 1'b1;
  end

  // State register, sweep counter and init-done flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ic_q       <= '0;
      initdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (!initen) initdone_q <= 1'b1;
        end
        ST_INIT: begin
          if (m_acc) begin
            if (ic_q == IC_LAST) begin
              ic_q       <= '0;
              initdone_q <= 1'b1;
            end else begin
              ic_q <= ic_q + (AW+1)'(1);
            end
          end
        end
        ST_RUN: begin
          if (initreq) initdone_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Arbitration pointer and read-owner tracking move only on a RUN accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= '0;
      rown_q  <= '0;
      rpend_q <= 1'b0;
    end else begin
      rpend_q <= (state_q == ST_RUN) && m_acc && (m_wr == '0);
      if ((state_q == ST_RUN) && m_acc) begin
        rown_q <= g;
        ptr_q  <= (int'(g) == NREQ - 1) ? '0 : g + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_sramarb.sv
// Directed bench for core_sramarb: two requesters, 16-word sweep.
module tb_core_sramarb;
  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 64;
  localparam int BC   = 8;
  localparam int WCNT = 16;

  logic                 clk;
  logic                 resetn;
  logic                 initen;
  logic                 initreq;
  logic                 initdone;
  logic [NREQ-1:0]      req_cs;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*BC-1:0]   req_wr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_rvalid;
  logic [DW-1:0]        req_rdata;
  logic                 m_cs;
  logic [AW-1:0]        m_addr;
  logic [BC-1:0]        m_wr;
  logic [DW-1:0]        m_wdata;
  logic [DW-1:0]        m_rdata;
  logic                 m_ready;

  int errors = 0;
  int checks = 0;

  core_sramarb #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .BC(BC), .WCNT(WCNT), .INITVAL('0)
  ) dut (
    .clk(clk), .resetn(resetn), .initen(initen), .initreq(initreq),
    .initdone(initdone), .req_cs(req_cs), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata), .req_ready(req_ready),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata), .m_cs(m_cs),
    .m_addr(m_addr), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic ie);
    resetn = 1'b0; initen = ie; initreq = 1'b0;
    req_cs = '0; req_addr = '0; req_wr = '0; req_wdata = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; initen = 1'b1; initreq = 1'b1;
    req_cs = 2'b11; req_addr = 16'h0905; req_wr = 16'hFFFF; req_wdata = '1;
    m_ready = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
    repeat (2) tick();
    checks++; if (m_cs !== 1'b0) begin errors++; $display("FAIL rst_m_cs got %b want 0", m_cs); end
    checks++; if (m_addr !== '0) begin errors++; $display("FAIL rst_m_addr got %h want 0", m_addr); end
    checks++; if (m_wr !== '0) begin errors++; $display("FAIL rst_m_wr got %h want 0", m_wr); end
    checks++; if (m_wdata !== '0) begin errors++; $display("FAIL rst_m_wdata got %h want 0", m_wdata); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
    checks++; if (req_rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b want 00", req_rvalid); end
    checks++; if (initdone !== 1'b0) begin errors++; $display("FAIL rst_initdone got %b want 0", initdone); end
    checks++; if (req_rdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rst_rdata got %h want 0123456789abcdef", req_rdata); end
  endtask

  task automatic test_zero_fill;
    apply_reset(1'b1);
    req_cs = 2'b11;
    #1;
    checks++; if (m_cs !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL zf_idle got cs=%b rdy=%b want cs=0 rdy=00", m_cs, req_ready); end
    for (int n = 0; n < WCNT; n++) begin
      tick();
      checks++; if (m_cs !== 1'b1 || m_addr !== AW'(n)) begin errors++; $display("FAIL zf_addr n=%0d got cs=%b addr=%0d want cs=1 addr=%0d", n, m_cs, m_addr, n); end
      checks++; if (m_wr !== 8'hFF || m_wdata !== 64'd0) begin errors++; $display("FAIL zf_data n=%0d got wr=%h data=%h want wr=ff data=0", n, m_wr, m_wdata); end
      checks++; if (req_ready !== 2'b00 || initdone !== 1'b0) begin errors++; $display("FAIL zf_busy n=%0d got rdy=%b done=%b want rdy=00 done=0", n, req_ready, initdone); end
    end
    tick();
    checks++; if (initdone !== 1'b1) begin errors++; $display("FAIL zf_done_cycle17 got %b want 1", initdone); end
  endtask

  task automatic test_skip_init;
    apply_reset(1'b0);
    #1;
    checks++; if (initdone !== 1'b0) begin errors++; $display("FAIL skip_idle_done got %b want 0", initdone); end
    tick();
    checks++; if (initdone !== 1'b1) begin errors++; $display("FAIL skip_done got %b want 1", initdone); end
    checks++; if (m_cs !== 1'b0 || m_addr !== '0) begin errors++; $display("FAIL skip_quiet got cs=%b addr=%h want cs=0 addr=0", m_cs, m_addr); end
    req_cs = 2'b01; req_addr[7:0] = 8'd5; req_wr = '0;
    #1;
    checks++; if (m_cs !== 1'b1 || m_addr !== 8'd5 || m_wr !== 8'h00) begin errors++; $display("FAIL skip_req got cs=%b addr=%0d wr=%h want cs=1 addr=5 wr=00", m_cs, m_addr, m_wr); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL skip_ready got %b want 01", req_ready); end
    tick();
    req_cs = 2'b00; m_rdata = 64'hA5A5_0000_1111_2222;
    #1;
    checks++; if (req_rvalid !== 2'b01) begin errors++; $display("FAIL skip_rvalid got %b want 01", req_rvalid); end
    checks++; if (req_rdata !== 64'hA5A5_0000_1111_2222) begin errors++; $display("FAIL skip_rdata got %h want a5a5000011112222", req_rdata); end
    tick();
    checks++; if (req_rvalid !== 2'b00) begin errors++; $display("FAIL skip_rvalid_end got %b want 00", req_rvalid); end
  endtask

  task automatic test_round_robin;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_rdy;
    apply_reset(1'b0);
    tick();
    req_cs = 2'b11;
    req_addr = {8'd9, 8'd3};
    req_wr = {8'hF0, 8'h0F};
    req_wdata = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_addr = (k % 2 == 0) ? 8'd3 : 8'd9;
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (m_addr !== exp_addr || req_ready !== exp_rdy) begin errors++; $display("FAIL rr_alt k=%0d got addr=%0d rdy=%b want addr=%0d rdy=%b", k, m_addr, req_ready, exp_addr, exp_rdy); end
      checks++; if (m_wr !== ((k % 2 == 0) ? 8'h0F : 8'hF0)) begin errors++; $display("FAIL rr_wr k=%0d got %h", k, m_wr); end
      checks++; if (req_rvalid !== 2'b00) begin errors++; $display("FAIL rr_no_rvalid k=%0d got %b want 00", k, req_rvalid); end
      tick();
    end
    req_cs = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (m_addr !== 8'd9 || req_ready !== 2'b10 || m_wdata !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL rr_solo k=%0d got addr=%0d rdy=%b data=%h want addr=9 rdy=10", k, m_addr, req_ready, m_wdata); end
      tick();
    end
    req_cs = 2'b00;
  endtask

  task automatic test_wait_cycles;
    apply_reset(1'b0);
    tick();
    req_cs = 2'b11; req_addr = {8'd7, 8'd2}; req_wr = '0; m_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01 || m_addr !== 8'd2) begin errors++; $display("FAIL wait_c1 got rdy=%b addr=%0d want rdy=01 addr=2", req_ready, m_addr); end
    tick();
    req_cs = 2'b10; m_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00 || m_addr !== 8'd7 || m_cs !== 1'b1) begin errors++; $display("FAIL wait_c2 got rdy=%b addr=%0d cs=%b want rdy=00 addr=7 cs=1", req_ready, m_addr, m_cs); end
    checks++; if (req_rvalid !== 2'b01) begin errors++; $display("FAIL wait_rvalid0 got %b want 01", req_rvalid); end
    tick();
    req_cs = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00 || m_addr !== 8'd7) begin errors++; $display("FAIL wait_c3_ptr got rdy=%b addr=%0d want rdy=00 addr=7", req_ready, m_addr); end
    checks++; if (req_rvalid !== 2'b00) begin errors++; $display("FAIL wait_c3_rvalid got %b want 00", req_rvalid); end
    tick();
    m_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10 || m_addr !== 8'd7) begin errors++; $display("FAIL wait_c4 got rdy=%b addr=%0d want rdy=10 addr=7", req_ready, m_addr); end
    tick();
    m_ready = 1'b0;
    #1;
    checks++; if (req_rvalid !== 2'b10) begin errors++; $display("FAIL wait_rvalid1 got %b want 10", req_rvalid); end
    checks++; if (m_addr !== 8'd2) begin errors++; $display("FAIL wait_ptr_adv got addr=%0d want 2", m_addr); end
    tick();
    req_cs = 2'b00; m_ready = 1'b1;
  endtask

  task automatic test_reinit;
    req_cs = 2'b01; req_addr[7:0] = 8'd4; req_wr = '0; m_ready = 1'b1; initreq = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01 || m_addr !== 8'd4 || initdone !== 1'b1) begin errors++; $display("FAIL reinit_acc got rdy=%b addr=%0d done=%b want rdy=01 addr=4 done=1", req_ready, m_addr, initdone); end
    tick();
    req_cs = 2'b11;
    #1;
    checks++; if (req_rvalid !== 2'b01) begin errors++; $display("FAIL reinit_rvalid got %b want 01", req_rvalid); end
    checks++; if (initdone !== 1'b0) begin errors++; $display("FAIL reinit_done_fall got %b want 0", initdone); end
    for (int n = 0; n < WCNT; n++) begin
      if (n == 10) initreq = 1'b0;
      #1;
      checks++; if (m_cs !== 1'b1 || m_addr !== AW'(n) || m_wr !== 8'hFF) begin errors++; $display("FAIL reinit_sweep n=%0d got cs=%b addr=%0d wr=%h want cs=1 addr=%0d wr=ff", n, m_cs, m_addr, m_wr, n); end
      checks++; if (req_ready !== 2'b00 || initdone !== 1'b0) begin errors++; $display("FAIL reinit_busy n=%0d got rdy=%b done=%b want rdy=00 done=0", n, req_ready, initdone); end
      tick();
    end
    checks++; if (initdone !== 1'b1) begin errors++; $display("FAIL reinit_done_rise got %b want 1", initdone); end
    req_cs = 2'b00;
  endtask

  task automatic test_reset_mid_sweep;
    apply_reset(1'b1);
    tick();
    repeat (7) tick();
    #1;
    checks++; if (m_addr !== 8'd7 || m_cs !== 1'b1) begin errors++; $display("FAIL mid_pre got addr=%0d cs=%b want addr=7 cs=1", m_addr, m_cs); end
    resetn = 1'b0;
    #1;
    checks++; if (m_cs !== 1'b0 || m_addr !== '0 || m_wr !== '0 || m_wdata !== '0) begin errors++; $display("FAIL mid_rst got cs=%b addr=%h wr=%h data=%h want all 0", m_cs, m_addr, m_wr, m_wdata); end
    checks++; if (req_ready !== 2'b00 || req_rvalid !== 2'b00 || initdone !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got rdy=%b rv=%b done=%b want 00 00 0", req_ready, req_rvalid, initdone); end
    tick();
    resetn = 1'b1;
    #1;
    checks++; if (m_cs !== 1'b0) begin errors++; $display("FAIL mid_idle got cs=%b want 0", m_cs); end
    tick();
    checks++; if (m_cs !== 1'b1 || m_addr !== 8'd0) begin errors++; $display("FAIL mid_restart0 got cs=%b addr=%0d want cs=1 addr=0", m_cs, m_addr); end
    tick();
    checks++; if (m_addr !== 8'd1) begin errors++; $display("FAIL mid_restart1 got addr=%0d want 1", m_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_skip_init();
    test_round_robin();
    test_wait_cycles();
    test_reinit();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
